// File: rtl/in_pkt_builder_if.sv
// rtl/in_pkt_builder_if.sv - IN FIFO read port and transmit byte stream between the packet builder and its neighbours
interface in_pkt_builder_if;
  logic       in_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output in_req,
    output in_ready,
    output tx_data,
    output tx_valid,
    input  in_data,
    input  in_valid,
    input  tx_ready
  );

  modport slave (
    input  in_req,
    input  in_ready,
    input  tx_data,
    input  tx_valid,
    output in_data,
    output in_valid,
    output tx_ready
  );
endinterface

// File: rtl/in_pkt_builder.sv
// rtl/in_pkt_builder.sv - builds a USB full-speed DATA0/DATA1 packet (PID, payload, inverted CRC16) for an IN transaction
module in_pkt_builder #(
  parameter int IN_MAXPACKETSIZE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_start_i,
  input  logic             data_toggle_i,
  input  logic             abort_i,
  in_pkt_builder_if.master bus,
  output logic             tx_done_o,
  output logic             busy_o
);
  localparam int CNT_W = $clog2(IN_MAXPACKETSIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IN_MAXPACKETSIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_FETCH,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       settle_q, settle_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             in_req_q, in_req_d;
  logic             tx_done_q, tx_done_d;
  logic             in_ready;
  logic             accept;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), data bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign accept = tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    settle_d   = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    in_req_d   = in_req_q;
    tx_done_d  = 1'b0;
    in_ready   = 1'b0;

    if (abort_i) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      in_req_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_start_i) begin
            in_req_d   = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = data_toggle_i ? 8'h4B : 8'hC3;
            crc_d      = 16'hFFFF;
            cnt_d      = '0;
            settle_d   = 2'd2;
            state_d    = S_PID;
          end
        end
        S_PID, S_DATA: begin
          if (accept) begin
            tx_valid_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        S_FETCH: begin
          // settle lets the FIFO's registered valid catch up with in_req or the last pop
          if (settle_q == 2'd0) begin
            if (cnt_q == CNT_MAX || !bus.in_valid) begin
              tx_data_d  = ~crc_q[7:0];
              tx_valid_d = 1'b1;
              state_d    = S_CRC_LO;
            end else begin
              in_ready   = 1'b1;
              tx_data_d  = bus.in_data;
              tx_valid_d = 1'b1;
              crc_d      = crc16_byte(crc_q, bus.in_data);
              cnt_d      = cnt_q + CNT_W'(1);
              settle_d   = 2'd2;
              state_d    = S_DATA;
            end
          end
        end
        S_CRC_LO: begin
          if (accept) begin
            tx_data_d = ~crc_q[15:8];
            state_d   = S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (accept) begin
            tx_valid_d = 1'b0;
            in_req_d   = 1'b0;
            tx_done_d  = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      crc_q      <= 16'hFFFF;
      cnt_q      <= '0;
      settle_q   <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      in_req_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      in_req_q   <= in_req_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign bus.in_req   = in_req_q;
  assign bus.in_ready = in_ready;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign tx_done_o    = tx_done_q;
  assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_in_pkt_builder.sv
// tb/tb_in_pkt_builder.sv - checks in_pkt_builder (max packet 8 and 16) against a FIFO model and a packet-level reference
module tb_in_pkt_builder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_start, data_toggle, abort;
  logic [1:0] tx_done, busy;
  logic       tx_rdy, man_rdy, clr, mon_clr;
  int         thr;
  int         fifo_n;
  logic [7:0] fifo_mem [64];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_fail = 0;

  in_pkt_builder_if bus [2] ();

  // Instance 0: max packet 8; instance 1: max packet 16. Both share stimulus and FIFO contents.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    in_pkt_builder #(.IN_MAXPACKETSIZE(g == 0 ? 8 : 16)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .tx_start_i   (tx_start),
      .data_toggle_i(data_toggle),
      .abort_i      (abort),
      .bus          (bus[g]),
      .tx_done_o    (tx_done[g]),
      .busy_o       (busy[g])
    );

    int         rd_ptr;
    logic       fvalid;
    logic [7:0] stream [$];
    int         pulses, dones, viol, cyc_g, last_rdy;
    logic       held, rst_prev, abort_prev;
    logic [7:0] held_data;

    always @(posedge clk) begin
      if (clr) begin
        rd_ptr <= 0;
        fvalid <= 1'b0;
      end else begin
        if (bus[g].in_ready && fvalid) rd_ptr <= rd_ptr + 1;
        fvalid <= bus[g].in_req && (rd_ptr < fifo_n);
      end
    end
    assign bus[g].in_valid = fvalid;
    assign bus[g].in_data  = fifo_mem[rd_ptr[5:0]];
    assign bus[g].tx_ready = tx_rdy;

    always @(negedge clk) begin
      if (clr || mon_clr) begin
        stream.delete();
        pulses = 0; dones = 0; viol = 0; cyc_g = 0; last_rdy = -100;
        held = 1'b0; rst_prev = 1'b0; abort_prev = 1'b0; held_data = 8'h00;
      end else begin
        cyc_g++;
        if (bus[g].tx_valid && bus[g].tx_ready) stream.push_back(bus[g].tx_data);
        if (bus[g].in_ready) begin
          if (!bus[g].in_valid || (cyc_g - last_rdy) < 3) viol++;
          pulses++;
          last_rdy = cyc_g;
        end
        if (tx_done[g]) dones++;
        if (bus[g].in_req !== busy[g]) viol++;
        if (held && !rst_prev && !abort_prev &&
            (bus[g].tx_valid !== 1'b1 || bus[g].tx_data !== held_data)) viol++;
        held       = bus[g].tx_valid && !bus[g].tx_ready;
        held_data  = bus[g].tx_data;
        rst_prev   = rst;
        abort_prev = abort;
      end
    end
  end

  // tx_ready pattern: 0 always, 1 random, 2 one cycle in 32, other manual
  int cyc = 0;
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #2;
      cyc++;
      case (thr)
        0:       tx_rdy = 1'b1;
        1:       tx_rdy = 1'($urandom_range(0, 1));
        2:       tx_rdy = (cyc % 32 == 0);
        default: tx_rdy = man_rdy;
      endcase
    end
  end

  typedef struct {
    int         n;
    logic [7:0] base;
    bit         tog;
    int         thr;
    int         p8;
    int         p16;
    int         left8;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs(input int g);
    if (g == 0) return {bus[0].in_req, bus[0].in_ready, bus[0].tx_valid, tx_done[0], busy[0], bus[0].tx_data};
    return {bus[1].in_req, bus[1].in_ready, bus[1].tx_valid, tx_done[1], busy[1], bus[1].tx_data};
  endfunction

  // Reference packet: PID, up to mps bytes from the FIFO starting at off, then ~CRC16 low/high.
  task automatic build_exp(input int mps, input bit tog, input int off);
    int take;
    logic [15:0] c;
    take = fifo_n - off;
    if (take > mps) take = mps;
    if (take < 0) take = 0;
    exp_q.delete();
    exp_q.push_back(tog ? 8'h4B : 8'hC3);
    c = 16'hFFFF;
    for (int i = 0; i < take; i++) begin
      exp_q.push_back(fifo_mem[off + i]);
      for (int b = 0; b < 8; b++)
        c = (c >> 1) ^ ((c[0] ^ fifo_mem[off + i][b]) ? 16'hA001 : 16'h0000);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic check_stream(input string name, input int g, input bit tog, input int off);
    logic [7:0] act [$];
    int bad;
    build_exp(g == 0 ? 8 : 16, tog, off);
    if (g == 0) act = g_dut[0].stream;
    else        act = g_dut[1].stream;
    n_cmp++;
    bad = -1;
    if (act.size() != exp_q.size()) bad = 999;
    else for (int i = 0; i < act.size(); i++) if (bad < 0 && act[i] !== exp_q[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      if (bad == 999) $display("FAIL %s: got %0d bytes, expected %0d bytes", name, act.size(), exp_q.size());
      else $display("FAIL %s: byte %0d got 0x%0h, expected 0x%0h", name, bad, act[bad], exp_q[bad]);
    end
  endtask

  task automatic load(input int n, input logic [7:0] base, input bit rnd);
    fifo_n = n;
    for (int i = 0; i < 64; i++) fifo_mem[i] = rnd ? 8'($urandom) : base + 8'(i);
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
  endtask

  task automatic start(input bit tog);
    tx_start = 1'b1; data_toggle = tog;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((g_dut[0].dones == 0 || g_dut[1].dones == 0) && k < 6000) begin
      tick(); k++;
    end
    check({name, "_done_in_time"}, 32'(k < 6000), 32'd1);
    repeat (5) tick();
  endtask

  task automatic check_pkt(input string name, input bit tog, input int off, input int p8, input int p16);
    check_stream({name, "_stream8"}, 0, tog, off);
    check_stream({name, "_stream16"}, 1, tog, off);
    check({name, "_pulses8"}, 32'(g_dut[0].pulses), 32'(p8));
    check({name, "_pulses16"}, 32'(g_dut[1].pulses), 32'(p16));
    check({name, "_dones"}, {16'(g_dut[0].dones), 16'(g_dut[1].dones)}, {16'd1, 16'd1});
    check({name, "_protocol_viol"}, 32'(g_dut[0].viol + g_dut[1].viol), 32'd0);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, n, p8, p16;
    bit tg;
    rst = 1'b1; tx_start = 1'b0; data_toggle = 1'b0; abort = 1'b0;
    man_rdy = 1'b0; thr = 0; clr = 1'b1; mon_clr = 1'b0; fifo_n = 0;
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'h00;
    repeat (3) tick();
    check("reset_outs8", 32'(outs(0)), 32'd0);
    check("reset_outs16", 32'(outs(1)), 32'd0);
    rst = 1'b0; clr = 1'b0;
    tick();

    vecs[0] = '{9,  8'h31, 1'b0, 0, 8, 9,  1};
    vecs[1] = '{0,  8'h00, 1'b1, 0, 0, 0,  0};
    vecs[2] = '{10, 8'hA0, 1'b0, 0, 8, 10, 2};
    vecs[3] = '{10, 8'hA0, 1'b0, 2, 8, 10, 2};
    vecs[4] = '{16, 8'h00, 1'b1, 1, 8, 16, 8};
    vecs[5] = '{20, 8'hF0, 1'b0, 1, 8, 16, 12};
    vecs[6] = '{1,  8'h7E, 1'b1, 2, 1, 1,  0};

    for (int v = 0; v < 7; v++) begin
      load(vecs[v].n, vecs[v].base, 1'b0);
      thr = vecs[v].thr;
      start(vecs[v].tog);
      wait_done($sformatf("vec%0d", v));
      check_pkt($sformatf("vec%0d", v), vecs[v].tog, 0, vecs[v].p8, vecs[v].p16);
      check($sformatf("vec%0d_left8", v), 32'(fifo_n - g_dut[0].rd_ptr), 32'(vecs[v].left8));
      if (v == 0) begin
        check("vec0_len16", 32'(g_dut[1].stream.size()), 32'd12);
        if (g_dut[1].stream.size() == 12)
          check("vec0_crc16", {g_dut[1].stream[10], g_dut[1].stream[11]}, {8'hC8, 8'hB4});
      end
      if (v == 1 && g_dut[0].stream.size() == 3)
        check("vec1_zlp", {g_dut[0].stream[0], g_dut[0].stream[1], g_dut[0].stream[2]}, 24'h4B0000);
    end

    for (int r = 0; r < 20; r++) begin
      n  = $urandom_range(0, 20);
      tg = 1'($urandom_range(0, 1));
      load(n, 8'h00, 1'b1);
      thr = $urandom_range(0, 1);
      start(tg);
      wait_done($sformatf("rnd%0d", r));
      p8  = (n < 8) ? n : 8;
      p16 = (n < 16) ? n : 16;
      check_pkt($sformatf("rnd%0d", r), tg, 0, p8, p16);
    end

    // abort while the third data byte is on the bus, then restart on the next cycle
    load(10, 8'h50, 1'b0);
    thr = 0;
    start(1'b0);
    k = 0;
    while (g_dut[0].pulses < 3 && k < 500) begin tick(); k++; end
    check("abort_reach3", 32'(g_dut[0].pulses), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs8", {bus[0].in_req, bus[0].tx_valid, busy[0], tx_done[0], bus[0].in_ready}, 5'b0);
    check("abort_outs16", {bus[1].in_req, bus[1].tx_valid, busy[1], tx_done[1], bus[1].in_ready}, 5'b0);
    check("abort_dones", 32'(g_dut[0].dones + g_dut[1].dones), 32'd0);
    mon_clr = 1'b1;
    start(1'b1);
    mon_clr = 1'b0;
    wait_done("after_abort");
    check_pkt("after_abort", 1'b1, 3, 7, 7);

    // start pulse while busy must be dropped
    load(3, 8'h11, 1'b0);
    thr = 0;
    start(1'b0);
    repeat (3) tick();
    start(1'b1);
    wait_done("busy_start");
    repeat (40) tick();
    check_pkt("busy_start", 1'b0, 0, 3, 3);

    // reset while CRC_LO is held, with a stray start while busy
    load(0, 8'h00, 1'b0);
    thr = 3; man_rdy = 1'b0;
    start(1'b1);
    tick();
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    repeat (4) tick();
    check("crclo_held8", {bus[0].tx_valid, busy[0], bus[0].tx_data}, {1'b1, 1'b1, 8'h00});
    start(1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_outs8", 32'(outs(0)), 32'd0);
    check("rst_mid_outs16", 32'(outs(1)), 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("rst_no_restart", 32'(busy), 32'd0);
    check("rst_no_done", 32'(g_dut[0].dones + g_dut[1].dones), 32'd0);
    mon_clr = 1'b1;
    thr = 0;
    start(1'b1);
    mon_clr = 1'b0;
    wait_done("after_rst");
    check_pkt("after_rst", 1'b1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/in_pkt_builder.md
# in_pkt_builder

Builds a USB 2.0 full-speed DATA0/DATA1 packet for an IN transaction. It sits between the IN FIFO and the byte-level transmit serializer (bit-stuffing/NRZI stage). On a start request it emits the data PID, then pulls up to IN_MAXPACKETSIZE bytes from the IN FIFO through that FIFO's request/valid/ready interface. It finishes with the inverted CRC16 of the payload, low byte first.

## Interface
- IN_MAXPACKETSIZE, 8: maximum payload bytes per packet (1..64).
- clk_i  input  1  system clock, 12MHz*BIT_SAMPLES domain.
- rst_i  input  1  reset; synchronous and active-high.
- tx_start_i  input  1  one-cycle pulse from the SIE on a valid IN token; ignored unless idle.
- data_toggle_i  input  1  sampled with tx_start_i: 0 selects DATA0 (PID 0xC3), 1 selects DATA1 (PID 0x4B).
- abort_i  input  1  bus reset/timeout from the SIE; cancels the packet.
- in_req_o  output  1  to FIFO in_req; high for the whole transaction.
- in_data_i  input  8  FIFO in_data.
- in_valid_i  input  1  FIFO in_valid.
- in_ready_o  output  1  to FIFO in_ready; single-cycle consume pulse.
- tx_data_o  output  8  byte to serializer.
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  serializer accepts tx_data_o when tx_valid_o && tx_ready_i.
- tx_done_o  output  1  one-cycle pulse after the last CRC byte is accepted.
- busy_o  output  1  high in every state except IDLE.

## Operation
- States: IDLE, PID, FETCH, DATA, CRC_LO, CRC_HI.
- Internal registers:
  - crc[15:0]: USB CRC16, poly 0x8005, reflected (LSB-first), init 0xFFFF.
  - cnt: width ceil_log2(IN_MAXPACKETSIZE+1).
  - settle: 2-bit counter; decrements each cycle while nonzero, in any state.
- IDLE, on tx_start_i:
  - Set in_req_o=1, tx_data_o=PID, tx_valid_o=1.
  - Set crc=0xFFFF, cnt=0, settle=2.
  - Go to PID.
- PID: hold the byte until accepted, then go to FETCH with tx_valid_o=0.
- FETCH: wait while settle!=0. Once settle==0:
  - If cnt==IN_MAXPACKETSIZE or in_valid_i==0: go to CRC_LO with tx_data_o=~crc[7:0] and tx_valid_o=1.
  - Otherwise, in the same cycle: in_ready_o=1; latch in_data_i into tx_data_o; tx_valid_o<=1; fold the byte into crc; cnt++; settle<=2; go to DATA.
- DATA: hold until accepted, then go to FETCH with tx_valid_o=0.
- CRC_LO: on accept, tx_data_o<=~crc[15:8] and go to CRC_HI.
- CRC_HI: on accept:
  - tx_valid_o=0, in_req_o=0.
  - tx_done_o=1 for the next cycle.
  - Go to IDLE.
- in_ready_o is asserted only in FETCH, and only at the cycle in_data_i is sampled. It never pulses twice within 3 cycles, which matches the FIFO's one-clock-per-byte rule and its registered valid update.
- Empty FIFO at start produces a zero-length packet: PID, 0x00, 0x00.
- A full packet stops at IN_MAXPACKETSIZE bytes even if in_valid_i stays high.
- Whether the FIFO commits or rewinds its read pointer (ACK or retry) is handled by the FIFO, not by this block.
- abort_i: the next state is IDLE. in_req_o, tx_valid_o and in_ready_o go low, and tx_done_o is not pulsed.
- Priority: rst_i > abort_i > tx_start_i. tx_start_i while busy_o is dropped.

## Timing
- Reset values: in_req_o=0, in_ready_o=0, tx_valid_o=0, tx_data_o=0x00, tx_done_o=0, busy_o=0, state IDLE.
- tx_start_i sampled at edge N: in_req_o, tx_valid_o and the PID are visible after N.
- First FIFO sample: no earlier than 3 cycles after in_req_o rises. This covers the 1-cycle FIFO latency of in_req to in_valid.
- Between a consume pulse and the next sample: at least 2 idle cycles (settle), so in_valid_i reflects the advanced pointer.
- tx_data_o is stable while tx_valid_o=1 and not accepted. tx_valid_o never drops without an accept (except on abort or reset).
- in_req_o falls at the same edge tx_valid_o falls after CRC_HI. tx_done_o is high exactly one cycle, after that edge.
- Reset or abort mid-packet leaves no residual pulses. A tx_start_i in the cycle after recovery starts a clean packet.

## Test plan
- IN_MAXPACKETSIZE=16, DATA0, FIFO holds 0x31..0x39 -> stream C3 31 32 33 34 35 36 37 38 39 C8 B4, nine in_ready_o pulses, one tx_done_o.
- Empty FIFO, data_toggle_i=1 -> stream 4B 00 00, zero in_ready_o pulses, in_req_o high throughout, then tx_done_o.
- Default size 8, FIFO holds 10 bytes -> PID, exactly 8 data bytes, 2 CRC bytes; exactly 8 in_ready_o pulses; FIFO still non-empty.
- tx_ready_i high for one cycle every 32 -> tx_data_o held stable between accepts, no extra in_ready_o, same byte sequence as the unthrottled case.
- abort_i during the 3rd data byte -> next cycle in_req_o=0, tx_valid_o=0, busy_o=0, no tx_done_o; a following tx_start_i yields a complete packet.
- rst_i mid-CRC_LO and tx_start_i while busy -> all outputs at reset values after the reset edge; the mid-packet start pulse causes no second packet.
